// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local timer (mtime/mtimecmp) and software interrupt on a req/ack bus
module clint_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  timer_interrupt_o,
  output logic                  software_interrupt_o
);

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_MSIP        = 3'd4;
  localparam logic [2:0] OFF_CTRL        = 3'd5;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  msip;
  logic                  en;
  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] cnt;

  logic                  accept;
  logic                  wr;
  logic                  rd;
  logic                  tick;
  logic [2:0]            off;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr;

  assign accept      = req_i && !ack_o;
  assign wr          = accept && we_i;
  assign rd          = accept && !we_i;
  assign off         = addr_i[4:2];
  assign tick        = en && (cnt == presc);
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};

  // MTIME_HI returns the shadow captured by the last MTIME_LO read, so LO-then-HI is atomic
  always_comb begin
    rd_word = '0;
    case (off)
      OFF_MTIME_LO:    rd_word = DATA_WIDTH'(mtime[31:0]);
      OFF_MTIME_HI:    rd_word = DATA_WIDTH'(hi_shadow);
      OFF_MTIMECMP_LO: rd_word = DATA_WIDTH'(mtimecmp[31:0]);
      OFF_MTIMECMP_HI: rd_word = DATA_WIDTH'(mtimecmp[63:32]);
      OFF_MSIP:        rd_word = DATA_WIDTH'(msip);
      OFF_CTRL:        rd_word = DATA_WIDTH'({presc, en});
      default:         rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime                <= '0;
      mtimecmp             <= '1;
      hi_shadow            <= '0;
      msip                 <= 1'b0;
      en                   <= 1'b1;
      presc                <= '0;
      cnt                  <= '0;
      ack_o                <= 1'b0;
      rdata_o              <= '0;
      timer_interrupt_o    <= 1'b0;
      software_interrupt_o <= 1'b0;
    end else begin
      ack_o                <= accept;
      rdata_o              <= rd ? rd_word : '0;
      timer_interrupt_o    <= (mtime >= mtimecmp);
      software_interrupt_o <= msip;

      if (rd && off == OFF_MTIME_LO) hi_shadow <= mtime[63:32];

      // a bus write to either half wins over the tick in the same cycle
      if (wr && off == OFF_MTIME_LO)      mtime[31:0]  <= wdata_i[31:0];
      else if (wr && off == OFF_MTIME_HI) mtime[63:32] <= wdata_i[31:0];
      else if (tick)                      mtime        <= mtime + 64'd1;

      if (wr && off == OFF_MTIMECMP_LO) mtimecmp[31:0]  <= wdata_i[31:0];
      if (wr && off == OFF_MTIMECMP_HI) mtimecmp[63:32] <= wdata_i[31:0];
      if (wr && off == OFF_MSIP)        msip            <= wdata_i[0];

      if (wr && off == OFF_CTRL) begin
        en    <= wdata_i[0];
        presc <= wdata_i[PRESCALE_W:1];
        cnt   <= '0;
      end else if (en) begin
        cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - bench for clint_timer: directed scenarios plus random traffic against a reference model
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        timer_interrupt_o;
  logic        software_interrupt_o;

  clint_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRESCALE_W(16)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_i                (req),
    .we_i                 (we),
    .addr_i               (addr),
    .wdata_i              (wdata),
    .ack_o                (ack_o),
    .rdata_o              (rdata_o),
    .timer_interrupt_o    (timer_interrupt_o),
    .software_interrupt_o (software_interrupt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mtime advances once every (PRESC+1) enabled cycles since the last CTRL write
  bit [63:0]       m_time, m_cmp;
  bit [31:0]       m_shadow, m_rdata;
  bit              m_msip, m_en, m_ack, m_ti, m_si;
  int unsigned     m_presc;
  longint unsigned m_phase;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit        acc, tick;
    bit [2:0]  off;
    bit [31:0] rv;
    bit [63:0] nt;
    m_valid = 1'b1;
    if (rst) begin
      m_time = 0; m_cmp = '1; m_msip = 0; m_en = 1; m_presc = 0; m_phase = 0;
      m_shadow = 0; m_ack = 0; m_rdata = 0; m_ti = 0; m_si = 0;
    end else begin
      acc  = req && !m_ack;
      off  = addr[4:2];
      tick = m_en && ((m_phase % (m_presc + 1)) == m_presc);
      case (off)
        3'd0:    rv = m_time[31:0];
        3'd1:    rv = m_shadow;
        3'd2:    rv = m_cmp[31:0];
        3'd3:    rv = m_cmp[63:32];
        3'd4:    rv = {31'b0, m_msip};
        3'd5:    rv = {15'b0, m_presc[15:0], m_en};
        default: rv = 0;
      endcase
      m_ti    = (m_time >= m_cmp);
      m_si    = m_msip;
      m_rdata = (acc && !we) ? rv : 32'd0;
      m_ack   = acc;
      if (acc && !we && off == 3'd0) m_shadow = m_time[63:32];
      nt = tick ? m_time + 64'd1 : m_time;
      if (m_en) m_phase++;
      if (acc && we) begin
        case (off)
          3'd0: nt = {m_time[63:32], wdata};
          3'd1: nt = {wdata, m_time[31:0]};
          3'd2: m_cmp[31:0] = wdata;
          3'd3: m_cmp[63:32] = wdata;
          3'd4: m_msip = wdata[0];
          3'd5: begin m_en = wdata[0]; m_presc = wdata[16:1]; m_phase = 0; end
          default: ;
        endcase
      end
      m_time = nt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ack_o", ack_o, m_ack);
      chk("rdata_o", rdata_o, m_rdata);
      chk("timer_interrupt_o", timer_interrupt_o, m_ti);
      chk("software_interrupt_o", software_interrupt_o, m_si);
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    chk("bus_ack", ack_o, 1'b1);
    r = rdata_o;
  endtask

  logic [31:0] rd, r0, r1, lo, hi;
  int          n;
  bit          ok;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ti", timer_interrupt_o, 1'b0);
    rst = 1'b0;

    repeat (4) @(posedge clk);
    bus(1'b0, 32'h00, 32'h0, rd);
    chk("idle_mtime_lo", rd, 32'd5);
    chk("idle_ti", timer_interrupt_o, 1'b0);

    bus(1'b1, 32'h14, 32'h7, rd);
    bus(1'b0, 32'h00, 32'h0, r0);
    repeat (40) @(posedge clk);
    bus(1'b0, 32'h00, 32'h0, r1);
    chk("presc3_advance", r1 - r0, 32'd10);
    bus(1'b0, 32'h14, 32'h0, rd);
    chk("ctrl_read", rd, 32'h7);

    bus(1'b1, 32'h14, 32'h0, rd);
    bus(1'b0, 32'h00, 32'h0, r0);
    repeat (20) @(posedge clk);
    bus(1'b0, 32'h00, 32'h0, r1);
    chk("frozen_advance", r1 - r0, 32'd0);

    bus(1'b1, 32'h14, 32'h1, rd);
    bus(1'b1, 32'h04, 32'h0, rd);
    bus(1'b1, 32'h00, 32'h0, rd);
    bus(1'b1, 32'h0C, 32'h0, rd);
    bus(1'b1, 32'h08, 32'h20, rd);
    chk("ti_low_before", timer_interrupt_o, 1'b0);
    for (int i = 0; i < 200 && !timer_interrupt_o; i++) @(negedge clk);
    chk("ti_rise", timer_interrupt_o, 1'b1);
    repeat (5) @(negedge clk);
    chk("ti_stays", timer_interrupt_o, 1'b1);
    bus(1'b1, 32'h08, 32'hFFFF_FFFF, rd);
    chk("ti_at_cmp_write", timer_interrupt_o, 1'b1);
    @(posedge clk); #1;
    chk("ti_fall", timer_interrupt_o, 1'b0);

    bus(1'b1, 32'h04, 32'h0, rd);
    bus(1'b1, 32'h00, 32'hFFFF_FFFE, rd);
    for (int k = 0; k < 3; k++) begin
      bus(1'b0, 32'h00, 32'h0, lo);
      bus(1'b0, 32'h04, 32'h0, hi);
      if (k == 0) begin
        chk("carry_first_lo", lo, 32'hFFFF_FFFF);
        chk("carry_first_hi", hi, 32'h0);
      end
      ok = (hi == 32'd0 && lo >= 32'hFFFF_FFF0) || (hi == 32'd1 && lo <= 32'hF);
      chk("carry_pair", ok, 1'b1);
    end

    bus(1'b1, 32'h10, 32'hFFFF_FFFF, rd);
    @(posedge clk); #1;
    chk("si_set", software_interrupt_o, 1'b1);
    bus(1'b0, 32'h10, 32'h0, rd);
    chk("msip_read", rd, 32'h1);
    bus(1'b1, 32'h10, 32'h0, rd);
    @(posedge clk); #1;
    chk("si_clear", software_interrupt_o, 1'b0);

    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h18; n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_o) n++;
    end
    req = 1'b0;
    chk("sustained_acks", n, 3);
    bus(1'b0, 32'h18, 32'h0, rd);
    chk("unmapped_read", rd, 32'h0);

    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h08;
    @(posedge clk); #1;
    chk("pre_rst_ack", ack_o, 1'b1);
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_ack", ack_o, 1'b0);
    req = 1'b1;
    @(posedge clk); #1;
    chk("rst_with_req_ack", ack_o, 1'b0);
    req = 1'b0; rst = 1'b0;
    bus(1'b0, 32'h08, 32'h0, rd);
    chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(1'b0, 32'h0C, 32'h0, rd);
    chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus(1'b0, 32'h10, 32'h0, rd);
    chk("rst_msip", rd, 32'h0);
    bus(1'b0, 32'h14, 32'h0, rd);
    chk("rst_ctrl", rd, 32'h1);

    repeat (3000) begin
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 499) == 0);
      req  = $urandom_range(0, 2) != 0;
      we   = $urandom_range(0, 1) != 0;
      addr = ($urandom & ~32'h1C) | (32'($urandom_range(0, 7)) << 2);
      case (addr[4:2])
        3'd0:    wdata = $urandom_range(0, 400);
        3'd1:    wdata = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0;
        3'd2:    wdata = $urandom_range(0, 500);
        3'd3:    wdata = ($urandom_range(0, 5) == 0) ? 32'd1 : 32'd0;
        3'd5:    wdata = (32'($urandom_range(0, 3)) << 1) | 32'(($urandom_range(0, 4) != 0));
        default: wdata = $urandom;
      endcase
    end
    rst = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
